// File: rtl/bin2bcd_stream.sv
// Streaming binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with valid/ready on both sides, optional two's-complement input and digit count.
module bin2bcd_stream #(
  parameter int NBITS  = 8,
  parameter int NDECS  = 3,
  parameter int SIGNED = 0,
  parameter int CNTW   = $clog2(NDECS + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NBITS-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NDECS*4-1:0]   out_bcd,
  output logic                 out_neg,
  output logic [CNTW-1:0]      out_ndigits
);

  localparam int BW = NDECS * 4;
  localparam int KW = $clog2(NBITS + 1);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  // Largest magnitude that can reach the shifter: 2^(NBITS-1) when signed, 2^NBITS-1 otherwise.
  localparam longint RANGE = (SIGNED != 0) ? (longint'(1) << (NBITS - 1))
                                           : (longint'(1) << NBITS);

  generate
    if (pow10(NDECS) <= RANGE) begin : g_range_check
      $error("bin2bcd_stream: NDECS too small to hold every NBITS input");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_n;
  logic [KW-1:0]       cnt, cnt_n;
  logic [NBITS-1:0]    mag, mag_n, load_mag;
  logic [BW-1:0]       bcd, bcd_n, adj;
  logic                neg, neg_n, load_neg;
  logic                accept;
  logic [BW+NBITS-1:0] shifted;

  assign in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = !reset && (state == DONE);
  assign out_bcd   = bcd;
  assign out_neg   = neg;

  assign load_neg  = (SIGNED != 0) && in_data[NBITS-1];
  assign load_mag  = load_neg ? -in_data : in_data;

  always_comb begin
    adj = bcd;
    for (int i = 0; i < NDECS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    // The top digit never reaches 8 after correction, so its MSB can be dropped.
    shifted = {adj[BW-2:0], mag, 1'b0};
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    mag_n   = mag;
    bcd_n   = bcd;
    neg_n   = neg;
    case (state)
      CONV: begin
        bcd_n = shifted[NBITS +: BW];
        mag_n = shifted[NBITS-1:0];
        cnt_n = cnt - KW'(1);
        if (cnt == KW'(1)) state_n = DONE;
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: begin
      end
    endcase
    if (accept) begin
      mag_n   = load_mag;
      neg_n   = load_neg;
      bcd_n   = '0;
      cnt_n   = KW'(NBITS);
      state_n = CONV;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mag   <= '0;
      bcd   <= '0;
      neg   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      mag   <= mag_n;
      bcd   <= bcd_n;
      neg   <= neg_n;
    end
  end

  always_comb begin
    out_ndigits = CNTW'(1);
    for (int i = 1; i < NDECS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) out_ndigits = CNTW'(i + 1);
    end
  end

endmodule

// File: tb/tb_bin2bcd_stream.sv
// Self-checking bench: scoreboard on an 8-bit unsigned converter, plus directed
// checks on a 16-bit unsigned and an 8-bit signed instance.
module tb_bin2bcd_stream;

  logic        clock = 1'b0;
  logic        reset;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // 8-bit unsigned instance
  logic        in_valid, in_ready, out_valid, out_ready, out_neg;
  logic [7:0]  in_data;
  logic [11:0] out_bcd;
  logic [1:0]  out_ndigits;
  logic        or_fixed, rand_mode, rnd;
  assign out_ready = rand_mode ? rnd : or_fixed;
  always @(posedge clock) rnd <= 1'($urandom_range(0, 1));

  bin2bcd_stream #(.NBITS(8), .NDECS(3), .SIGNED(0)) u8 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_neg(out_neg), .out_ndigits(out_ndigits));

  // 16-bit unsigned instance
  logic        v16, r16, ov16, neg16, or16;
  logic [15:0] d16;
  logic [19:0] bcd16;
  logic [2:0]  nd16;

  bin2bcd_stream #(.NBITS(16), .NDECS(5), .SIGNED(0)) u16 (
    .clock(clock), .reset(reset), .in_valid(v16), .in_ready(r16),
    .in_data(d16), .out_valid(ov16), .out_ready(or16),
    .out_bcd(bcd16), .out_neg(neg16), .out_ndigits(nd16));

  // 8-bit signed instance
  logic        vs, rs, ovs, negs, ors;
  logic [7:0]  ds;
  logic [11:0] bcds;
  logic [1:0]  nds;

  bin2bcd_stream #(.NBITS(8), .NDECS(3), .SIGNED(1)) us (
    .clock(clock), .reset(reset), .in_valid(vs), .in_ready(rs),
    .in_data(ds), .out_valid(ovs), .out_ready(ors),
    .out_bcd(bcds), .out_neg(negs), .out_ndigits(nds));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [11:0] bcd;
    int          nd;
  } exp_t;
  exp_t q[$];
  int acc_edge, pop_edge;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] dec(input int unsigned v, input int nd);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int ndig(input int unsigned v);
    int n;
    n = 1;
    while (v >= 10) begin
      v = v / 10;
      n++;
    end
    return n;
  endfunction

  // Result monitor: a handshake seen at a negedge completes on the following posedge.
  always @(negedge clock) begin
    if (!reset && out_valid && out_ready) begin
      check("sb_has_entry", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        pop_edge = cyc + 1;
        check("out_bcd", 32'(out_bcd), 32'(e.bcd));
        check("out_ndigits", 32'(out_ndigits), e.nd);
        check("out_neg", 32'(out_neg), 0);
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input int v);
    int n;
    exp_t e;
    logic [19:0] full;
    n = 0;
    in_valid = 1'b1;
    in_data  = 8'(v);
    @(negedge clock);
    while (!in_ready && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("accept_ready", 32'(in_ready), 1);
    if (in_ready) begin
      full = dec(v, 3);
      e.bcd = full[11:0];
      e.nd  = ndig(v);
      q.push_back(e);
      acc_edge = cyc + 1;
    end
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("latency", 32'(cyc - acc_edge), lat);
  endtask

  task automatic conv16(input int unsigned v);
    int n, a;
    v16 = 1'b1;
    d16 = 16'(v);
    @(negedge clock);
    check("in_ready16", 32'(r16), 1);
    a = cyc + 1;
    @(posedge clock);
    #1 v16 = 1'b0;
    n = 0;
    @(negedge clock);
    while (!ov16 && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("latency16", 32'(cyc - a), 16);
    check("bcd16", 32'(bcd16), 32'(dec(v, 5)));
    check("nd16", 32'(nd16), ndig(v));
    check("neg16", 32'(neg16), 0);
    @(posedge clock);
    #1;
  endtask

  task automatic convs(input logic [7:0] v);
    int n, a;
    int unsigned m;
    logic [19:0] full;
    m = v[7] ? 256 - int'(v) : int'(v);
    full = dec(m, 3);
    vs = 1'b1;
    ds = v;
    @(negedge clock);
    check("in_ready_s", 32'(rs), 1);
    a = cyc + 1;
    @(posedge clock);
    #1 vs = 1'b0;
    n = 0;
    @(negedge clock);
    while (!ovs && n < 40) begin
      @(negedge clock);
      n++;
    end
    check("latency_s", 32'(cyc - a), 8);
    check("bcd_s", 32'(bcds), 32'(full[11:0]));
    check("nd_s", 32'(nds), ndig(m));
    check("neg_s", 32'(negs), 32'(v[7]));
    @(posedge clock);
    #1;
  endtask

  initial begin
    int dir[7] = '{255, 0, 7, 10, 99, 100, 128};
    logic [11:0] snap;
    logic seen;
    int n;

    reset = 1'b1; in_valid = 1'b0; in_data = '0; or_fixed = 1'b1; rand_mode = 1'b0;
    v16 = 1'b0; d16 = '0; or16 = 1'b1; vs = 1'b0; ds = '0; ors = 1'b1;
    acc_edge = 0; pop_edge = -1;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_bcd", 32'(out_bcd), 0);
    check("rst_out_neg", 32'(out_neg), 0);
    check("rst_in_ready16", 32'(r16), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("idle_in_ready", 32'(in_ready), 1);
    check("idle_out_valid", 32'(out_valid), 0);
    @(posedge clock);
    #1;

    foreach (dir[i]) begin
      send(dir[i]);
      wait_valid(8);
      @(posedge clock);
      #1;
    end

    // Backpressure: hold the result, then release together with a new word.
    or_fixed = 1'b0;
    send(123);
    wait_valid(8);
    snap = out_bcd;
    repeat (5) begin
      @(negedge clock);
      check("bp_bcd_stable", 32'(out_bcd), 32'(snap));
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
    end
    @(posedge clock);
    #1 or_fixed = 1'b1;
    send(77);
    check("bp_same_edge", 32'(acc_edge), 32'(pop_edge));
    wait_valid(8);
    @(posedge clock);
    #1;

    // Reset three cycles into a conversion.
    send(100);
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    @(negedge clock);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    @(posedge clock);
    #1 reset = 1'b0;
    q.delete();
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("no_result_after_rst", 32'(seen), 0);
    @(posedge clock);
    #1;
    send(42);
    wait_valid(8);
    @(posedge clock);
    #1;

    // Full sweep with random consumer stalls.
    rand_mode = 1'b1;
    for (int v = 0; v < 256; v++) send(v);
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    check("sb_drained", 32'(q.size()), 0);
    @(posedge clock);
    #1 rand_mode = 1'b0;

    conv16(65535);
    conv16(40960);
    conv16(0);
    conv16(9);

    convs(8'h80);
    convs(8'hFF);
    convs(8'h7F);
    convs(8'h00);
    convs(8'h9C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
